// File: rtl/alu_pkg.sv
// Shared types for the digit-serial ALU: opcode encoding and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOTA = 3'b101,
        OP_SHL1 = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_digit.sv
// Combinational digit slice: one DIGIT-wide step of the ALU with carry in/out.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  alu_op_t          op,
    input  logic             cin,
    input  logic             shin,
    output logic [DIGIT-1:0] res,
    output logic             cout
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;
    logic [DIGIT:0]   shl;

    // SUB runs as A + ~B + 1, the +1 coming from the preset carry.
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
    assign shl   = {a, shin};

    always_comb begin
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res  = sum[DIGIT-1:0];
                cout = sum[DIGIT];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOTA: res = ~a;
            OP_SHL1: begin
                res  = shl[DIGIT-1:0];
                cout = shl[DIGIT];
            end
            default: begin
                res  = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: LSD-first, DIGIT bits per clock, start/busy/done handshake.
module alu_serial
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DIGIT = 1,
    localparam int N     = WIDTH / DIGIT,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             on,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [2:0]       op,
    output logic [WIDTH:0]   out,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    alu_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    alu_op_t          op_q;
    logic             carry_q;
    logic [WIDTH:0]   out_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT-1:0]       dig_res;
    logic                   dig_cout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_d;
    logic                   fin_carry;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .op   (op_q),
        .cin  (carry_q),
        .shin (carry_q),
        .res  (dig_res),
        .cout (dig_cout)
    );

    // New digit enters at the top; after N steps the result is LSD-aligned.
    assign res_cat   = {dig_res, res_q};
    assign res_d     = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign fin_carry = (op_q == OP_SUB) ? ~dig_cout : dig_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            out_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (on) begin
                        a_q     <= ina;
                        b_q     <= inb;
                        op_q    <= alu_op_t'(op);
                        res_q   <= '0;
                        count_q <= '0;
                        carry_q <= (alu_op_t'(op) == OP_SUB);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_d;
                    carry_q <= dig_cout;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        out_q   <= {fin_carry, res_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
